// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port synchronous data memory between the CPU MEM stage
//   (port C) and the GPU/vector unit (port G). It registers at most one grant
//   per cycle, issues the memory command in the grant cycle, and routes the
//   one-cycle-latency read data back to the port that owns the read. It also
//   produces the CPU stall. Arbitration is round-robin, or CPU-first when
//   CPU_PRIORITY = 1, with a starvation counter that bounds how long G can lose.
//   All state changes on the falling edge of I_CLOCK. I_LOCK is an
//   asynchronous, active-low reset.
// Ports
//   I_CLOCK, I_LOCK                       clock (negedge active), async reset
//   I_CPU_Req/We/Addr/WData               CPU request (byte address)
//   O_CPU_Gnt/RValid/RData/Stall          CPU grant, read return, stall
//   I_GPU_Req/We/Addr/WData               GPU request (byte address)
//   O_GPU_Gnt/RValid/RData/Err            GPU grant, read return, MMIO drop
//   O_MEM_En/We/Addr/WData, I_MEM_RData   memory command and read data
module dmem_arbiter #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 16,
   parameter int CPU_PRIORITY = 0,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  I_CLOCK,
   input  logic                  I_LOCK,
   input  logic                  I_CPU_Req,
   input  logic                  I_CPU_We,
   input  logic [15:0]           I_CPU_Addr,
   input  logic [DATA_WIDTH-1:0] I_CPU_WData,
   output logic                  O_CPU_Gnt,
   output logic                  O_CPU_RValid,
   output logic [DATA_WIDTH-1:0] O_CPU_RData,
   output logic                  O_CPU_Stall,
   input  logic                  I_GPU_Req,
   input  logic                  I_GPU_We,
   input  logic [15:0]           I_GPU_Addr,
   input  logic [DATA_WIDTH-1:0] I_GPU_WData,
   output logic                  O_GPU_Gnt,
   output logic                  O_GPU_RValid,
   output logic [DATA_WIDTH-1:0] O_GPU_RData,
   output logic                  O_GPU_Err,
   output logic                  O_MEM_En,
   output logic                  O_MEM_We,
   output logic [ADDR_WIDTH-1:0] O_MEM_Addr,
   output logic [DATA_WIDTH-1:0] O_MEM_WData,
   input  logic [DATA_WIDTH-1:0] I_MEM_RData
);

   typedef enum logic {PORT_C = 1'b0, PORT_G = 1'b1} port_e;

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic                  cpu_gnt_q, cpu_gnt_d;
   logic                  gpu_gnt_q, gpu_gnt_d;
   logic                  gpu_err_q, gpu_err_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   port_e                 last_q, last_d;
   logic [CNT_W-1:0]      starve_q, starve_d;
   logic                  rd_vld_q, rd_vld_d;
   port_e                 rd_own_q, rd_own_d;

   logic c_elig, g_elig, win_c, win_g, g_mmio;

   // Byte-address bits above the word address and the CPU byte-select bit
   // are not needed here; the MEM stage handles sub-word access.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{I_CPU_Addr[15:ADDR_WIDTH+1], I_CPU_Addr[0],
                               I_GPU_Addr[15:ADDR_WIDTH+1]};

   always_comb begin
      // A port whose grant is currently visible is not eligible, so a held
      // request is not granted twice.
      c_elig      = I_CPU_Req & ~cpu_gnt_q;
      g_elig      = I_GPU_Req & ~gpu_gnt_q;
      win_c       = 1'b0;
      win_g       = 1'b0;
      starve_d    = starve_q;
      last_d      = last_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (c_elig && g_elig) begin
         if (CPU_PRIORITY != 0) begin
            if (starve_q == LIMIT) begin
               win_g = 1'b1;
            end else begin
               win_c    = 1'b1;
               starve_d = starve_q + 1'b1;
            end
         end else if (last_q == PORT_C) begin
            win_g = 1'b1;
         end else begin
            win_c = 1'b1;
         end
      end else begin
         win_c = c_elig;
         win_g = g_elig;
      end

      if (win_g) starve_d = '0;

      if (win_c) begin
         last_d      = PORT_C;
         mem_we_d    = I_CPU_We;
         mem_addr_d  = I_CPU_Addr[ADDR_WIDTH:1];
         mem_wdata_d = I_CPU_WData;
      end else if (win_g) begin
         last_d      = PORT_G;
         mem_we_d    = I_GPU_We;
         mem_addr_d  = I_GPU_Addr[ADDR_WIDTH:1];
         mem_wdata_d = I_GPU_WData;
      end

      // G accesses to LEDR/LEDG/HEX are granted but never reach memory.
      g_mmio    = win_g && (I_GPU_Addr[9:0] inside {10'h3FC, 10'h3FD, 10'h3FE});
      cpu_gnt_d = win_c;
      gpu_gnt_d = win_g;
      gpu_err_d = g_mmio;
      mem_en_d  = (win_c | win_g) & ~g_mmio;

      // Track the read issued in the current grant cycle; its data returns
      // in the next cycle.
      rd_vld_d = mem_en_q & ~mem_we_q;
      rd_own_d = gpu_gnt_q ? PORT_G : PORT_C;
   end

   always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
      if (!I_LOCK) begin
         cpu_gnt_q   <= 1'b0;
         gpu_gnt_q   <= 1'b0;
         gpu_err_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         last_q      <= PORT_C;
         starve_q    <= '0;
         rd_vld_q    <= 1'b0;
         rd_own_q    <= PORT_C;
      end else begin
         cpu_gnt_q   <= cpu_gnt_d;
         gpu_gnt_q   <= gpu_gnt_d;
         gpu_err_q   <= gpu_err_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         last_q      <= last_d;
         starve_q    <= starve_d;
         rd_vld_q    <= rd_vld_d;
         rd_own_q    <= rd_own_d;
      end
   end

   assign O_CPU_Gnt    = cpu_gnt_q;
   assign O_GPU_Gnt    = gpu_gnt_q;
   assign O_GPU_Err    = gpu_err_q;
   assign O_MEM_En     = mem_en_q;
   assign O_MEM_We     = mem_we_q;
   assign O_MEM_Addr   = mem_addr_q;
   assign O_MEM_WData  = mem_wdata_q;
   assign O_CPU_RValid = rd_vld_q & (rd_own_q == PORT_C);
   assign O_GPU_RValid = rd_vld_q & (rd_own_q == PORT_G);
   assign O_CPU_RData  = O_CPU_RValid ? I_MEM_RData : '0;
   assign O_GPU_RData  = O_GPU_RValid ? I_MEM_RData : '0;

   // Stall while waiting for a grant, and through the grant cycle of a read.
   // Forced low during reset so every output is 0.
   assign O_CPU_Stall = I_LOCK & ((I_CPU_Req & ~cpu_gnt_q) | (cpu_gnt_q & ~mem_we_q));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. u_rr runs round-robin mode and is backed
//   by a small memory model; u_pri runs CPU-priority mode with STARVE_LIMIT=4
//   and shares the address/data/we stimulus but has its own request lines.
//   Inputs change 1 ns after the rising edge; the DUT acts on the falling edge.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        c_req, c_we, g_req, g_we;
   logic [15:0] c_addr, g_addr, c_wdata, g_wdata;
   logic        pc_req, pg_req;

   logic        cpu_gnt, cpu_rvalid, cpu_stall, gpu_gnt, gpu_rvalid, gpu_err;
   logic [15:0] cpu_rdata, gpu_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;

   logic        p_cpu_gnt, p_cpu_rvalid, p_cpu_stall, p_gpu_gnt, p_gpu_rvalid, p_gpu_err;
   logic [15:0] p_cpu_rdata, p_gpu_rdata;
   logic        p_mem_en, p_mem_we;
   logic [9:0]  p_mem_addr;
   logic [15:0] p_mem_wdata;

   logic [15:0] mem [0:1023];

   int total = 0;
   int bad   = 0;

   dmem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .CPU_PRIORITY(0), .STARVE_LIMIT(4)) u_rr (
      .I_CLOCK(clk), .I_LOCK(rst_n),
      .I_CPU_Req(c_req), .I_CPU_We(c_we), .I_CPU_Addr(c_addr), .I_CPU_WData(c_wdata),
      .O_CPU_Gnt(cpu_gnt), .O_CPU_RValid(cpu_rvalid), .O_CPU_RData(cpu_rdata),
      .O_CPU_Stall(cpu_stall),
      .I_GPU_Req(g_req), .I_GPU_We(g_we), .I_GPU_Addr(g_addr), .I_GPU_WData(g_wdata),
      .O_GPU_Gnt(gpu_gnt), .O_GPU_RValid(gpu_rvalid), .O_GPU_RData(gpu_rdata),
      .O_GPU_Err(gpu_err),
      .O_MEM_En(mem_en), .O_MEM_We(mem_we), .O_MEM_Addr(mem_addr),
      .O_MEM_WData(mem_wdata), .I_MEM_RData(mem_rdata)
   );

   dmem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .CPU_PRIORITY(1), .STARVE_LIMIT(4)) u_pri (
      .I_CLOCK(clk), .I_LOCK(rst_n),
      .I_CPU_Req(pc_req), .I_CPU_We(c_we), .I_CPU_Addr(c_addr), .I_CPU_WData(c_wdata),
      .O_CPU_Gnt(p_cpu_gnt), .O_CPU_RValid(p_cpu_rvalid), .O_CPU_RData(p_cpu_rdata),
      .O_CPU_Stall(p_cpu_stall),
      .I_GPU_Req(pg_req), .I_GPU_We(g_we), .I_GPU_Addr(g_addr), .I_GPU_WData(g_wdata),
      .O_GPU_Gnt(p_gpu_gnt), .O_GPU_RValid(p_gpu_rvalid), .O_GPU_RData(p_gpu_rdata),
      .O_GPU_Err(p_gpu_err),
      .O_MEM_En(p_mem_en), .O_MEM_We(p_mem_we), .O_MEM_Addr(p_mem_addr),
      .O_MEM_WData(p_mem_wdata), .I_MEM_RData(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port memory behind u_rr: read data one cycle later.
   always @(negedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      // Request held during reset must not show up on any output.
      c_req = 1'b1;
      cyc();
      total++;
      if ({cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall, gpu_gnt, gpu_rvalid, gpu_rdata,
           gpu_err, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
         bad++;
         $display("FAIL reset_rr_outputs got gnt=%b/%b stall=%b en=%b addr=%h wdata=%h want all 0",
                  cpu_gnt, gpu_gnt, cpu_stall, mem_en, mem_addr, mem_wdata);
      end
      total++;
      if ({p_cpu_gnt, p_cpu_rvalid, p_cpu_rdata, p_cpu_stall, p_gpu_gnt, p_gpu_rvalid,
           p_gpu_rdata, p_gpu_err, p_mem_en, p_mem_we, p_mem_addr, p_mem_wdata} !== '0) begin
         bad++;
         $display("FAIL reset_pri_outputs got gnt=%b/%b stall=%b en=%b want all 0",
                  p_cpu_gnt, p_gpu_gnt, p_cpu_stall, p_mem_en);
      end
      c_req = 1'b0;
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_c_write();
      c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0010; c_wdata = 16'hBEEF;
      #1;
      total++;
      if (cpu_stall !== 1'b1) begin
         bad++; $display("FAIL wr_stall_before got=%b want=1", cpu_stall);
      end
      cyc();
      total++;
      if ({cpu_gnt, gpu_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 10'h008, 16'hBEEF}) begin
         bad++;
         $display("FAIL wr_grant got gnt=%b/%b en=%b we=%b addr=%h wdata=%h want 1/0 1 1 008 beef",
                  cpu_gnt, gpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
      end
      total++;
      if (cpu_stall !== 1'b0) begin
         bad++; $display("FAIL wr_stall_grant got=%b want=0", cpu_stall);
      end
      c_req = 1'b0;
      cyc();
      total++;
      if ({cpu_gnt, mem_en, mem_addr, mem_wdata} !== {2'b00, 10'h008, 16'hBEEF}) begin
         bad++;
         $display("FAIL wr_idle_hold got gnt=%b en=%b addr=%h wdata=%h want 0 0 008 beef",
                  cpu_gnt, mem_en, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_c_read_g_read();
      c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0004;
      #1;
      total++;
      if (cpu_stall !== 1'b1) begin
         bad++; $display("FAIL rd_stall_req got=%b want=1", cpu_stall);
      end
      cyc();
      total++;
      if ({cpu_gnt, mem_en, mem_we, mem_addr, cpu_stall} !== {3'b110, 10'h002, 1'b1}) begin
         bad++;
         $display("FAIL rd_c_grant got gnt=%b en=%b we=%b addr=%h stall=%b want 1 1 0 002 1",
                  cpu_gnt, mem_en, mem_we, mem_addr, cpu_stall);
      end
      c_req = 1'b0;
      g_req = 1'b1; g_we = 1'b0; g_addr = 16'h0010;
      cyc();
      total++;
      if ({cpu_rvalid, cpu_rdata, gpu_gnt, gpu_rvalid, gpu_rdata, cpu_stall} !==
          {1'b1, 16'h1234, 2'b10, 16'h0000, 1'b0}) begin
         bad++;
         $display("FAIL rd_c_return got rv=%b rd=%h ggnt=%b grv=%b grd=%h stall=%b want 1 1234 1 0 0000 0",
                  cpu_rvalid, cpu_rdata, gpu_gnt, gpu_rvalid, gpu_rdata, cpu_stall);
      end
      total++;
      if ({mem_en, mem_we, mem_addr} !== {2'b10, 10'h008}) begin
         bad++; $display("FAIL rd_g_cmd got en=%b we=%b addr=%h want 1 0 008", mem_en, mem_we, mem_addr);
      end
      g_req = 1'b0;
      cyc();
      total++;
      if ({gpu_rvalid, gpu_rdata, cpu_rvalid, cpu_rdata} !== {1'b1, 16'hBEEF, 1'b0, 16'h0000}) begin
         bad++;
         $display("FAIL rd_g_return got grv=%b grd=%h crv=%b crd=%h want 1 beef 0 0000",
                  gpu_rvalid, gpu_rdata, cpu_rvalid, cpu_rdata);
      end
   endtask

   task automatic test_reset_midread();
      c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0004;
      cyc();
      total++;
      if (cpu_gnt !== 1'b1) begin
         bad++; $display("FAIL rst_mid_grant got=%b want=1", cpu_gnt);
      end
      c_req = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if ({cpu_gnt, cpu_rvalid, cpu_stall, gpu_gnt, gpu_rvalid, gpu_err, mem_en, mem_we, mem_addr,
           mem_wdata} !== '0) begin
         bad++;
         $display("FAIL rst_mid_async got gnt=%b en=%b addr=%h wdata=%h want all 0",
                  cpu_gnt, mem_en, mem_addr, mem_wdata);
      end
      cyc();
      rst_n = 1'b1;
      cyc();
      total++;
      if ({cpu_rvalid, gpu_rvalid} !== 2'b00) begin
         bad++; $display("FAIL rst_mid_no_rvalid got=%b%b want=00", cpu_rvalid, gpu_rvalid);
      end
      c_req = 1'b1; g_req = 1'b1; c_we = 1'b1; g_we = 1'b1;
      cyc();
      total++;
      if ({cpu_gnt, gpu_gnt} !== 2'b01) begin
         bad++; $display("FAIL rst_mid_first_winner got c/g=%b%b want=01", cpu_gnt, gpu_gnt);
      end
      c_req = 1'b0; g_req = 1'b0;
      cyc();
   endtask

   task automatic test_round_robin();
      int n_c;
      int n_g;
      n_c = 0;
      n_g = 0;
      apply_reset();
      c_req = 1'b1; g_req = 1'b1; c_we = 1'b1; g_we = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (cpu_gnt) n_c++;
         if (gpu_gnt) n_g++;
         total++;
         if ({cpu_gnt, gpu_gnt, mem_en} !== (((i % 2) == 0) ? 3'b011 : 3'b101)) begin
            bad++;
            $display("FAIL rr_grant[%0d] got c/g/en=%b%b%b want %s", i, cpu_gnt, gpu_gnt, mem_en,
                     ((i % 2) == 0) ? "011" : "101");
         end
      end
      c_req = 1'b0; g_req = 1'b0;
      total++;
      if (n_c !== 4 || n_g !== 4) begin
         bad++; $display("FAIL rr_counts got c=%0d g=%0d want 4/4", n_c, n_g);
      end
      cyc();
   endtask

   task automatic test_priority();
      c_we = 1'b1; g_we = 1'b1;
      // Held requests: a just-granted port is ineligible, so C and G alternate.
      pc_req = 1'b1; pg_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         total++;
         if ({p_cpu_gnt, p_gpu_gnt} !== (((i % 2) == 0) ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL pri_cont[%0d] got c/g=%b%b want %s", i, p_cpu_gnt, p_gpu_gnt,
                     ((i % 2) == 0) ? "10" : "01");
         end
      end
      pc_req = 1'b0; pg_req = 1'b0;
      cyc();
      // G requests only on contention cycles and withdraws after losing.
      for (int r = 0; r < 6; r++) begin
         pc_req = 1'b1; pg_req = 1'b1;
         cyc();
         total++;
         if ({p_cpu_gnt, p_gpu_gnt} !== ((r == 4) ? 2'b01 : 2'b10)) begin
            bad++;
            $display("FAIL pri_starve[%0d] got c/g=%b%b want %s", r, p_cpu_gnt, p_gpu_gnt,
                     (r == 4) ? "01" : "10");
         end
         pc_req = 1'b0; pg_req = 1'b0;
         cyc();
      end
   endtask

   task automatic test_mmio();
      g_req = 1'b1; g_we = 1'b1; g_addr = 16'h03FE; g_wdata = 16'h5555;
      cyc();
      total++;
      if ({gpu_gnt, gpu_err, mem_en} !== 3'b110) begin
         bad++; $display("FAIL mmio_g_wr got gnt/err/en=%b%b%b want 110", gpu_gnt, gpu_err, mem_en);
      end
      g_req = 1'b0;
      cyc();
      total++;
      if ({gpu_gnt, gpu_err} !== 2'b00) begin
         bad++; $display("FAIL mmio_err_pulse got gnt/err=%b%b want 00", gpu_gnt, gpu_err);
      end
      g_req = 1'b1; g_we = 1'b0; g_addr = 16'h03FC;
      cyc();
      total++;
      if ({gpu_gnt, gpu_err, mem_en} !== 3'b110) begin
         bad++; $display("FAIL mmio_g_rd got gnt/err/en=%b%b%b want 110", gpu_gnt, gpu_err, mem_en);
      end
      g_req = 1'b0;
      cyc();
      total++;
      if (gpu_rvalid !== 1'b0) begin
         bad++; $display("FAIL mmio_g_rd_norv got=%b want=0", gpu_rvalid);
      end
      g_req = 1'b1; g_we = 1'b1; g_addr = 16'h03FF;
      cyc();
      total++;
      if ({gpu_gnt, gpu_err, mem_en, mem_addr} !== {3'b101, 10'h1FF}) begin
         bad++;
         $display("FAIL mmio_g_3ff got gnt/err/en=%b%b%b addr=%h want 101 1ff",
                  gpu_gnt, gpu_err, mem_en, mem_addr);
      end
      g_req = 1'b0;
      cyc();
      g_req = 1'b1; g_addr = 16'h03FB;
      cyc();
      total++;
      if ({gpu_gnt, gpu_err, mem_en, mem_addr} !== {3'b101, 10'h1FD}) begin
         bad++;
         $display("FAIL mmio_g_3fb got gnt/err/en=%b%b%b addr=%h want 101 1fd",
                  gpu_gnt, gpu_err, mem_en, mem_addr);
      end
      g_req = 1'b0;
      cyc();
      c_req = 1'b1; c_we = 1'b1; c_addr = 16'h03FE; c_wdata = 16'h00A5;
      cyc();
      total++;
      if ({cpu_gnt, gpu_err, mem_en, mem_we, mem_addr} !== {4'b1011, 10'h1FF}) begin
         bad++;
         $display("FAIL mmio_c_pass got gnt/err/en/we=%b%b%b%b addr=%h want 1011 1ff",
                  cpu_gnt, gpu_err, mem_en, mem_we, mem_addr);
      end
      c_req = 1'b0;
      cyc();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
      mem[2]    <= 16'h1234;
      mem_rdata <= 16'h0000;
      rst_n = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
      pc_req = 1'b0; pg_req = 1'b0;

      test_reset();
      test_c_write();
      test_c_read_g_read();
      test_reset_midread();
      test_round_robin();
      test_priority();
      test_mmio();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
